// File: rtl/extensor_pkg.sv
// extensor_pkg: extension mode encodings shared by the immediate extender.
package extensor_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_SIGN   = 2'b00;
    localparam mode_t MODE_ZERO   = 2'b01;
    localparam mode_t MODE_BRANCH = 2'b10;
    localparam mode_t MODE_UPPER  = 2'b11;
endpackage

// File: rtl/extensor_core.sv
// extensor_core: combinational immediate extension (sign/zero/branch/upper).
// EXTENSOR_OVF_EN adds ovf, flagging branch offsets that lose significant bits.
module extensor_core
    import extensor_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  mode_t            mode,
    output logic [OUT_W-1:0] data
`ifdef EXTENSOR_OVF_EN
    ,output logic            ovf
`endif
);
    logic signed [IN_W-1:0] simm;
    logic [OUT_W-1:0] sign, zero;
    assign simm = imm;
    assign sign = OUT_W'(simm);
    assign zero = OUT_W'(imm);
    always_comb begin
        data = mode == MODE_SIGN   ? sign :
               mode == MODE_ZERO   ? zero :
               mode == MODE_BRANCH ? sign << SHIFT :
                                     zero << (OUT_W - IN_W);
    end
`ifdef EXTENSOR_OVF_EN
    // shifted-out bits plus the new sign bit must all match to keep the value
    logic [SHIFT:0] top;
    assign top = sign[OUT_W-1 -: SHIFT+1];
    assign ovf = mode == MODE_BRANCH && top != '0 && top != '1;
`endif
endmodule

// File: rtl/extensor_sinal_pipe.sv
// extensor_sinal_pipe: pipelined immediate extender with valid/ready and a one-entry skid.
// EXTENSOR_OVF_EN adds the out_ovf port, carried with its entry.
module extensor_sinal_pipe
    import extensor_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef EXTENSOR_OVF_EN
    ,output logic            out_ovf
`endif
);
    logic [OUT_W-1:0] ext_data, skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic skid_valid, accept, out_load;
    logic ext_ovf, skid_ovf, ovf_q;

    extensor_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
        .imm  (in_imm),
        .mode (mode_t'(in_mode)),
        .data (ext_data)
`ifdef EXTENSOR_OVF_EN
        ,.ovf (ext_ovf)
`endif
    );

`ifdef EXTENSOR_OVF_EN
    assign out_ovf = ovf_q;
`else
    assign ext_ovf = 1'b0;
`endif

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            ovf_q      <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            skid_ovf   <= 1'b0;
        end else begin
            if (out_load) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_tag    <= skid_tag;
                    ovf_q      <= skid_ovf;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_data  <= ext_data;
                    out_tag   <= in_tag;
                    ovf_q     <= ext_ovf;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            // accept implies an empty skid, so only a held output diverts the input here
            if (accept && !out_load) begin
                skid_data  <= ext_data;
                skid_tag   <= in_tag;
                skid_ovf   <= ext_ovf;
                skid_valid <= 1'b1;
            end
        end
    end

`ifndef EXTENSOR_OVF_EN
    logic unused;
    assign unused = ^{ovf_q, skid_ovf};
`endif
endmodule

// File: tb/tb_extensor_sinal_pipe.sv
// tb_extensor_sinal_pipe: directed + random checks of the extender against a scoreboard model.
module tb_extensor_sinal_pipe;
    localparam int IN_W = 16, OUT_W = 32, SHIFT = 2, TAG_W = 5;

    logic clock = 0, reset = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [IN_W-1:0] in_imm = '0;
    logic [1:0] in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0, out_tag;
    logic [OUT_W-1:0] out_data;
    logic out_ovf;

    extensor_sinal_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef EXTENSOR_OVF_EN
        ,.out_ovf  (out_ovf)
`endif
    );
`ifndef EXTENSOR_OVF_EN
    assign out_ovf = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic ovf;
    } entry_t;
    entry_t exp_q[$];
    int errors = 0, checks = 0;

    // arithmetic model: interpret the immediate as a number, scale it, wrap to OUT_W
    function automatic entry_t model(logic [IN_W-1:0] imm, logic [1:0] mode, logic [TAG_W-1:0] tag);
        entry_t e;
        longint u = longint'(imm);
        longint s = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
        longint p = s * (longint'(1) << SHIFT);
        longint lim = longint'(1) << (OUT_W - 1);
        e.tag = tag;
        e.ovf = (mode == 2'd2) && (p < -lim || p >= lim);
        case (mode)
            2'd0: e.data = OUT_W'(s);
            2'd1: e.data = OUT_W'(u);
            2'd2: e.data = OUT_W'(p);
            default: e.data = OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
        endcase
        return e;
    endfunction

    task automatic chk(string name, logic [OUT_W-1:0] obs, logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [IN_W-1:0] imm, logic [1:0] mode, logic [TAG_W-1:0] tag);
        in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
    endtask

    // one clock: score a drain, record an accept, then step to #1 past the edge
    task automatic cycle();
        entry_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL spurious_output observed=%h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_tag", OUT_W'(out_tag), OUT_W'(e.tag));
                chk("sb_ovf", OUT_W'(out_ovf), OUT_W'(e.ovf));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_imm, in_mode, in_tag));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [OUT_W-1:0] prev_data;
        logic prev_hold;
        #1;
        cycle(); cycle();
        reset = 0;
        chk("rst_out_valid", OUT_W'(out_valid), 0);
        chk("rst_in_ready", OUT_W'(in_ready), 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", OUT_W'(out_tag), 0);

        out_ready = 1;
        drive(1, 16'hEFFF, 2'd0, 5'd3); cycle();
        chk("sign_neg_valid", OUT_W'(out_valid), 1);
        chk("sign_neg", out_data, 32'hFFFFEFFF);
        chk("sign_neg_tag", OUT_W'(out_tag), 3);
        drive(1, 16'h7FFF, 2'd0, 5'd4); cycle(); chk("sign_pos", out_data, 32'h00007FFF);
        drive(1, 16'hA40A, 2'd1, 5'd5); cycle(); chk("zero", out_data, 32'h0000A40A);
        drive(1, 16'h1234, 2'd3, 5'd6); cycle(); chk("upper", out_data, 32'h12340000);
        drive(1, 16'hFFFF, 2'd2, 5'd7); cycle(); chk("branch_neg", out_data, 32'hFFFFFFFC);
        drive(1, 16'h0004, 2'd2, 5'd8); cycle(); chk("branch_pos", out_data, 32'h00000010);
        drive(0, 0, 0, 0); cycle();
        chk("idle_valid", OUT_W'(out_valid), 0);

        out_ready = 0;
        drive(1, 16'h0001, 2'd1, 5'd10); cycle();
        chk("bp_a_out", out_data, 1);
        chk("bp_a_ready", OUT_W'(in_ready), 1);
        drive(1, 16'h0002, 2'd1, 5'd11); cycle();
        chk("bp_b_ready", OUT_W'(in_ready), 0);
        chk("bp_b_hold", out_data, 1);
        drive(1, 16'h0003, 2'd1, 5'd12);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_c_stall_ready", OUT_W'(in_ready), 0);
            chk("bp_c_stall_hold", out_data, 1);
        end
        out_ready = 1;
        cycle(); chk("bp_out_b", out_data, 2);
        cycle(); chk("bp_out_c", out_data, 3);
        drive(0, 0, 0, 0); cycle();
        chk("bp_done_valid", OUT_W'(out_valid), 0);
        chk("bp_queue_empty", OUT_W'(exp_q.size()), 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, IN_W'(i), 2'd1, TAG_W'(i)); cycle();
            chk("stream_ready", OUT_W'(in_ready), 1);
            chk("stream_data", out_data, OUT_W'(i));
        end
        drive(0, 0, 0, 0); cycle();

        prev_hold = 0; prev_data = '0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), IN_W'($urandom), 2'($urandom), TAG_W'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            if (prev_hold) chk("rand_hold_stable", out_data, prev_data);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            cycle();
        end
        drive(0, 0, 0, 0); out_ready = 1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        chk("rand_drained", OUT_W'(exp_q.size()), 0);

        out_ready = 0;
        drive(1, 16'h0011, 2'd0, 5'd1); cycle();
        drive(1, 16'h0022, 2'd0, 5'd2); cycle();
        chk("full_ready", OUT_W'(in_ready), 0);
        drive(0, 0, 0, 0);
        reset = 1; cycle(); reset = 0;
        exp_q.delete();
        chk("mid_rst_valid", OUT_W'(out_valid), 0);
        chk("mid_rst_ready", OUT_W'(in_ready), 1);
        chk("mid_rst_data", out_data, 0);
        out_ready = 1;
        drive(1, 16'h8000, 2'd2, 5'd9); cycle();
        chk("post_rst_data", out_data, 32'hFFFE0000);
        drive(0, 0, 0, 0); cycle();
        chk("post_rst_idle", OUT_W'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
